// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop bank toward a target pattern using the JK excitation
// table, reads Q back to confirm, retries a bounded number of times and reports pass/fail.
module jk_excitation_driver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 3,
    localparam int unsigned RW       = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_ok,
    output logic [RW-1:0]    rsp_retries,
    output logic [WIDTH-1:0] rsp_mism
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] target_r, target_n;
    logic [RW-1:0]    retry_r, retry_n;
    logic             ok_n;
    logic [RW-1:0]    retries_n;
    logic [WIDTH-1:0] mism_n;
    logic [WIDTH-1:0] mism;

    assign mism = q_in ^ target_r;

    // State and response registers; reset abandons any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            target_r    <= '0;
            retry_r     <= '0;
            rsp_ok      <= 1'b0;
            rsp_retries <= '0;
            rsp_mism    <= '0;
        end else begin
            state       <= state_n;
            target_r    <= target_n;
            retry_r     <= retry_n;
            rsp_ok      <= ok_n;
            rsp_retries <= retries_n;
            rsp_mism    <= mism_n;
        end
    end

    // J/K are combinational in DRIVE so they follow q_in and drop the instant reset clears state.
    always_comb begin
        state_n   = state;
        target_n  = target_r;
        retry_n   = retry_r;
        ok_n      = rsp_ok;
        retries_n = rsp_retries;
        mism_n    = rsp_mism;
        tgt_ready = 1'b0;
        rsp_valid = 1'b0;
        j_out     = '0;
        k_out     = '0;

        case (state)
            IDLE: begin
                tgt_ready = ~rst;
                if (tgt_valid) begin
                    target_n = tgt_data;
                    retry_n  = '0;
                    state_n  = DRIVE;
                end
            end
            DRIVE: begin
                j_out   = target_r & ~q_in;
                k_out   = ~target_r & q_in;
                state_n = CHECK;
            end
            CHECK: begin
                if (mism == '0) begin
                    ok_n      = 1'b1;
                    mism_n    = '0;
                    retries_n = retry_r;
                    state_n   = RESP;
                end else if (retry_r < RW'(MAX_RETRY)) begin
                    retry_n = retry_r + RW'(1);
                    state_n = DRIVE;
                end else begin
                    ok_n      = 1'b0;
                    mism_n    = mism;
                    retries_n = RW'(MAX_RETRY);
                    state_n   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
